// File: rtl/projectile_pkg.sv
// Shared types and constants for the multi-slot projectile engine.
package projectile_pkg;

   typedef enum logic [1:0] {
      WAIT_ST   = 2'd0,
      RUN_ST    = 2'd1,
      UPDATE_ST = 2'd2
   } state_t;

   localparam int PIX_W         = 11;
   localparam int FRAME_H       = 479;
   localparam int FRAME_W       = 639;
   localparam int SAFETY_MARGIN = 2;
   localparam int OBJ_SIZE      = 16;

   // Population count of up to eight live-slot flags.
   function automatic logic [3:0] count_ones(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/projectile_slot_alloc.sv
// Find-first-zero over the live-slot vector: lowest free slot index and a free flag.
module projectile_slot_alloc
   import projectile_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int IDX_W     = 2
) (
   input  logic [NUM_SLOTS-1:0] active,
   output logic [IDX_W-1:0]     free_idx,
   output logic                 any_free
);

   // Scan from the top down so the lowest free index wins.
   always_comb begin
      free_idx = '0;
      any_free = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!active[i]) begin
            free_idx = IDX_W'(i);
            any_free = 1'b1;
         end else begin
            free_idx = free_idx;
            any_free = any_free;
         end
      end
   end

endmodule

// File: rtl/projectile_pool.sv
// Multi-slot projectile engine: spawns shots at the ship muzzle, moves them once
// per frame in fixed point, and retires them on collision or at the frame limit.
module projectile_pool
   import projectile_pkg::*;
#(
   parameter int NUM_SLOTS       = 4,
   parameter int FP_SHIFT        = 6,
   parameter int SPEED_Y         = 10,
   parameter int DIR_UP          = 1,
   parameter int OFFSET_X        = 15,
   parameter int OFFSET_Y        = -2,
   parameter int Y_TOP           = 2,
   parameter int Y_BOTTOM        = FRAME_H - SAFETY_MARGIN - OBJ_SIZE,
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       startOfFrame,
   input  logic                       enable_sof,
   input  logic                       fire,
   input  logic [PIX_W-1:0]           ship_x,
   input  logic [PIX_W-1:0]           ship_y,
   input  logic [NUM_SLOTS-1:0]       collision,
   output logic [NUM_SLOTS-1:0]       active,
   output logic [NUM_SLOTS*PIX_W-1:0] proj_x,
   output logic [NUM_SLOTS*PIX_W-1:0] proj_y,
   output logic                       fire_accepted,
   output logic [3:0]                 num_active
);

   localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int POS_W = PIX_W + FP_SHIFT;
   localparam logic [POS_W:0] TOP_LIM   = (POS_W+1)'((Y_TOP << FP_SHIFT) + SPEED_Y);
   localparam logic [POS_W:0] BOT_LIM   = (POS_W+1)'(Y_BOTTOM << FP_SHIFT);
   localparam logic [POS_W:0] SPEED_EXT = (POS_W+1)'(SPEED_Y);

   state_t                state_r, state_next;
   logic [IDX_W-1:0]      idx_r, idx_next;
   logic [NUM_SLOTS-1:0]  active_r, hit_r, clr_mask_s;
   logic [POS_W-1:0]      pos_x_r [NUM_SLOTS];
   logic [POS_W-1:0]      pos_y_r [NUM_SLOTS];
   logic [7:0]            cooldown_r;
   logic                  fire_pending_r, fire_q_r, fire_accepted_r;
   logic [3:0]            num_active_r;
   logic                  spawn_s, consume_s, sof_go_s, sweep_s, fire_edge_s;
   logic [IDX_W-1:0]      free_idx_s;
   logic                  any_free_s;
   logic [PIX_W:0]        sum_x_s;
   logic signed [PIX_W+1:0] sum_y_s;
   logic [PIX_W-1:0]      spawn_px_x_s, spawn_px_y_s;

   projectile_slot_alloc #(
      .NUM_SLOTS (NUM_SLOTS),
      .IDX_W     (IDX_W)
   ) u_alloc (
      .active   (active_r),
      .free_idx (free_idx_s),
      .any_free (any_free_s)
   );

   assign fire_edge_s = fire & ~fire_q_r & enable_sof;

   // Muzzle position in pixels, saturated into the 11-bit coordinate range.
   always_comb begin
      sum_x_s = {1'b0, ship_x} + (PIX_W+1)'(OFFSET_X);
      sum_y_s = $signed({2'b00, ship_y}) + $signed((PIX_W+2)'(OFFSET_Y));
      if (sum_x_s[PIX_W]) begin
         spawn_px_x_s = {PIX_W{1'b1}};
      end else begin
         spawn_px_x_s = sum_x_s[PIX_W-1:0];
      end
      if (sum_y_s < $signed((PIX_W+2)'(0))) begin
         spawn_px_y_s = '0;
      end else if (sum_y_s > $signed((PIX_W+2)'(2047))) begin
         spawn_px_y_s = {PIX_W{1'b1}};
      end else begin
         spawn_px_y_s = sum_y_s[PIX_W-1:0];
      end
   end

   // Next-state and per-cycle control decisions.
   always_comb begin
      state_next = state_r;
      idx_next   = idx_r;
      spawn_s    = 1'b0;
      consume_s  = 1'b0;
      sof_go_s   = 1'b0;
      sweep_s    = 1'b0;
      case (state_r)
         WAIT_ST: begin
            if (startOfFrame && enable_sof) begin
               state_next = RUN_ST;
            end else begin
               state_next = WAIT_ST;
            end
         end
         RUN_ST: begin
            if (fire_pending_r) begin
               consume_s = 1'b1;
               spawn_s   = (cooldown_r == 8'd0) && any_free_s;
            end else begin
               consume_s = 1'b0;
            end
            if (startOfFrame && enable_sof) begin
               sof_go_s   = 1'b1;
               idx_next   = '0;
               state_next = UPDATE_ST;
            end else begin
               state_next = RUN_ST;
            end
         end
         UPDATE_ST: begin
            sweep_s = 1'b1;
            if (idx_r == IDX_W'(NUM_SLOTS - 1)) begin
               idx_next   = '0;
               state_next = RUN_ST;
            end else begin
               idx_next = idx_r + IDX_W'(1);
            end
         end
         default: begin
            state_next = WAIT_ST;
            idx_next   = '0;
         end
      endcase
   end

   // The sweep clears the slot it visits before new hits are merged in.
   always_comb begin
      if (sweep_s) begin
         clr_mask_s = NUM_SLOTS'(1) << idx_r;
      end else begin
         clr_mask_s = '0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= WAIT_ST;
         idx_r   <= '0;
      end else begin
         state_r <= state_next;
         idx_r   <= idx_next;
      end
   end

   // Slot datapath: spawn, per-frame motion, retirement, hit capture, cooldown.
   always_ff @(posedge clk) begin
      if (reset) begin
         active_r        <= '0;
         hit_r           <= '0;
         cooldown_r      <= 8'd0;
         fire_pending_r  <= 1'b0;
         fire_q_r        <= 1'b0;
         fire_accepted_r <= 1'b0;
         num_active_r    <= 4'd0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            pos_x_r[i] <= '0;
            pos_y_r[i] <= '0;
         end
      end else begin
         fire_q_r        <= fire;
         fire_pending_r  <= (fire_pending_r & ~consume_s) | fire_edge_s;
         fire_accepted_r <= spawn_s;
         num_active_r    <= count_ones(8'(active_r));
         hit_r           <= (hit_r & ~clr_mask_s) | (collision & active_r);

         if (spawn_s) begin
            cooldown_r <= 8'(COOLDOWN_FRAMES);
         end else if (sof_go_s && (cooldown_r != 8'd0)) begin
            cooldown_r <= cooldown_r - 8'd1;
         end else begin
            cooldown_r <= cooldown_r;
         end

         if (spawn_s) begin
            active_r[free_idx_s] <= 1'b1;
            pos_x_r[free_idx_s]  <= POS_W'(spawn_px_x_s) << FP_SHIFT;
            pos_y_r[free_idx_s]  <= POS_W'(spawn_px_y_s) << FP_SHIFT;
         end else if (sweep_s && active_r[idx_r]) begin
            if (hit_r[idx_r]) begin
               active_r[idx_r] <= 1'b0;
            end else if (DIR_UP != 0) begin
               // Retire before the subtraction could cross the top limit.
               if ({1'b0, pos_y_r[idx_r]} < TOP_LIM) begin
                  active_r[idx_r] <= 1'b0;
               end else begin
                  pos_y_r[idx_r] <= pos_y_r[idx_r] - POS_W'(SPEED_Y);
               end
            end else begin
               if (({1'b0, pos_y_r[idx_r]} + SPEED_EXT) > BOT_LIM) begin
                  active_r[idx_r] <= 1'b0;
               end else begin
                  pos_y_r[idx_r] <= pos_y_r[idx_r] + POS_W'(SPEED_Y);
               end
            end
         end else begin
            active_r <= active_r;
         end
      end
   end

   assign active        = active_r;
   assign fire_accepted = fire_accepted_r;
   assign num_active    = num_active_r;

   // Pixel outputs are the integer part of the fixed-point positions.
   always_comb begin
      proj_x = '0;
      proj_y = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         proj_x[i*PIX_W +: PIX_W] = pos_x_r[i][POS_W-1 -: PIX_W];
         proj_y[i*PIX_W +: PIX_W] = pos_y_r[i][POS_W-1 -: PIX_W];
      end
   end

endmodule

// File: tb/tb_projectile_pool.sv
// Directed self-checking bench for projectile_pool with default parameters.
module tb_projectile_pool;
   import projectile_pkg::*;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            startOfFrame = 1'b0;
   logic            enable_sof = 1'b0;
   logic            fire = 1'b0;
   logic [10:0]     ship_x = 11'd0;
   logic [10:0]     ship_y = 11'd0;
   logic [N-1:0]    collision = '0;
   logic [N-1:0]    active;
   logic [N*11-1:0] proj_x, proj_y;
   logic            fire_accepted;
   logic [3:0]      num_active;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   projectile_pool dut (
      .clk           (clk),
      .reset         (reset),
      .startOfFrame  (startOfFrame),
      .enable_sof    (enable_sof),
      .fire          (fire),
      .ship_x        (ship_x),
      .ship_y        (ship_y),
      .collision     (collision),
      .active        (active),
      .proj_x        (proj_x),
      .proj_y        (proj_y),
      .fire_accepted (fire_accepted),
      .num_active    (num_active)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         startOfFrame = 1'b1;
         step(1);
         startOfFrame = 1'b0;
         step(5);
      end
   endtask

   task automatic press(output int pulses);
      pulses = 0;
      fire = 1'b1;
      step(1);
      pulses += int'(fire_accepted);
      fire = 1'b0;
      repeat (3) begin
         step(1);
         pulses += int'(fire_accepted);
      end
   endtask

   task automatic restart();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      enable_sof = 1'b1;
      frames(1);
   endtask

   function automatic logic [10:0] px(input int i);
      return proj_x[i*11 +: 11];
   endfunction

   function automatic logic [10:0] py(input int i);
      return proj_y[i*11 +: 11];
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      step(2);
      checks++;
      if (active !== 4'b0000 || num_active !== 4'd0 || fire_accepted !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl active=%b num=%0d acc=%b expected 0000/0/0", active, num_active, fire_accepted);
      end
      checks++;
      if (proj_x !== '0 || proj_y !== '0) begin
         errors++;
         $display("FAIL reset_pos proj_x=%h proj_y=%h expected 0", proj_x, proj_y);
      end
   endtask

   task automatic test_spawn();
      ship_x = 11'd100;
      ship_y = 11'd400;
      restart();
      fire = 1'b1;
      step(1);
      checks++;
      if (fire_accepted !== 1'b0) begin
         errors++;
         $display("FAIL spawn_early acc=%b expected 0", fire_accepted);
      end
      fire = 1'b0;
      step(1);
      checks++;
      if (fire_accepted !== 1'b1 || active !== 4'b0001 || num_active !== 4'd0) begin
         errors++;
         $display("FAIL spawn_pulse acc=%b active=%b num=%0d expected 1/0001/0", fire_accepted, active, num_active);
      end
      step(1);
      checks++;
      if (fire_accepted !== 1'b0 || num_active !== 4'd1) begin
         errors++;
         $display("FAIL spawn_after acc=%b num=%0d expected 0/1", fire_accepted, num_active);
      end
      checks++;
      if (px(0) !== 11'd115 || py(0) !== 11'd398) begin
         errors++;
         $display("FAIL spawn_pos x=%0d y=%0d expected 115/398", px(0), py(0));
      end
   endtask

   task automatic test_motion();
      frames(64);
      checks++;
      if (py(0) !== 11'd388 || active !== 4'b0001) begin
         errors++;
         $display("FAIL motion_64 y=%0d active=%b expected 388/0001", py(0), active);
      end
      frames(2470);
      checks++;
      if (py(0) !== 11'd2 || active !== 4'b0001) begin
         errors++;
         $display("FAIL motion_edge y=%0d active=%b expected 2/0001", py(0), active);
      end
      frames(1);
      checks++;
      if (active !== 4'b0000 || py(0) !== 11'd2 || num_active !== 4'd0) begin
         errors++;
         $display("FAIL motion_retire active=%b y=%0d num=%0d expected 0000/2/0", active, py(0), num_active);
      end
   endtask

   task automatic test_fill();
      int p;
      logic [3:0] exp_a;
      restart();
      for (int k = 0; k < 4; k++) begin
         press(p);
         exp_a = 4'((1 << (k + 1)) - 1);
         checks++;
         if (p !== 1 || active !== exp_a || py(k) !== 11'd398) begin
            errors++;
            $display("FAIL fill_slot%0d pulses=%0d active=%b y=%0d expected 1/%b/398", k, p, active, py(k), exp_a);
         end
         frames(9);
      end
      press(p);
      checks++;
      if (p !== 0 || active !== 4'b1111 || num_active !== 4'd4) begin
         errors++;
         $display("FAIL fill_full pulses=%0d active=%b num=%0d expected 0/1111/4", p, active, num_active);
      end
   endtask

   task automatic test_cooldown();
      int p;
      restart();
      press(p);
      checks++;
      if (p !== 1) begin
         errors++;
         $display("FAIL cool_first pulses=%0d expected 1", p);
      end
      frames(3);
      press(p);
      checks++;
      if (p !== 0 || active !== 4'b0001) begin
         errors++;
         $display("FAIL cool_drop pulses=%0d active=%b expected 0/0001", p, active);
      end
      frames(6);
      press(p);
      checks++;
      if (p !== 1 || active !== 4'b0011) begin
         errors++;
         $display("FAIL cool_third pulses=%0d active=%b expected 1/0011", p, active);
      end
   endtask

   task automatic test_collision();
      int p;
      frames(9);
      press(p);
      checks++;
      if (p !== 1 || active !== 4'b0111) begin
         errors++;
         $display("FAIL coll_setup pulses=%0d active=%b expected 1/0111", p, active);
      end
      collision = 4'b1100;
      step(1);
      collision = 4'b0000;
      step(1);
      checks++;
      if (active !== 4'b0111) begin
         errors++;
         $display("FAIL coll_hold active=%b expected 0111", active);
      end
      frames(1);
      checks++;
      if (active !== 4'b0011 || num_active !== 4'd2) begin
         errors++;
         $display("FAIL coll_retire active=%b num=%0d expected 0011/2", active, num_active);
      end
      frames(9);
      press(p);
      checks++;
      if (p !== 1 || active !== 4'b0111 || py(2) !== 11'd398) begin
         errors++;
         $display("FAIL coll_reuse pulses=%0d active=%b y2=%0d expected 1/0111/398", p, active, py(2));
      end
   endtask

   task automatic test_reset_mid();
      int p;
      restart();
      press(p);
      frames(9);
      press(p);
      frames(9);
      press(p);
      checks++;
      if (active !== 4'b0111) begin
         errors++;
         $display("FAIL mid_setup active=%b expected 0111", active);
      end
      startOfFrame = 1'b1;
      step(1);
      startOfFrame = 1'b0;
      step(1);
      reset = 1'b1;
      step(1);
      checks++;
      if (active !== 4'b0000 || proj_x !== '0 || proj_y !== '0 || num_active !== 4'd0 || fire_accepted !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset active=%b x=%h y=%h num=%0d acc=%b expected all 0", active, proj_x, proj_y, num_active, fire_accepted);
      end
      checks++;
      if (dut.state_r !== WAIT_ST) begin
         errors++;
         $display("FAIL mid_state got %0d expected %0d", dut.state_r, WAIT_ST);
      end
      reset = 1'b0;
   endtask

   task automatic test_freeze();
      int p;
      enable_sof = 1'b1;
      frames(1);
      press(p);
      frames(1);
      checks++;
      if (p !== 1 || py(0) !== 11'd397) begin
         errors++;
         $display("FAIL frz_setup pulses=%0d y=%0d expected 1/397", p, py(0));
      end
      enable_sof = 1'b0;
      frames(5);
      press(p);
      checks++;
      if (p !== 0 || py(0) !== 11'd397 || active !== 4'b0001) begin
         errors++;
         $display("FAIL frz_hold pulses=%0d y=%0d active=%b expected 0/397/0001", p, py(0), active);
      end
      enable_sof = 1'b1;
      frames(6);
      press(p);
      checks++;
      if (p !== 0) begin
         errors++;
         $display("FAIL frz_cooldown pulses=%0d expected 0", p);
      end
      frames(1);
      press(p);
      checks++;
      if (p !== 1 || active !== 4'b0011 || py(0) !== 11'd396) begin
         errors++;
         $display("FAIL frz_resume pulses=%0d active=%b y=%0d expected 1/0011/396", p, active, py(0));
      end
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_motion();
      test_fill();
      test_cooldown();
      test_collision();
      test_reset_mid();
      test_freeze();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
